alu_mc: RTL and testbench

- Parametrised, handshaked successor to the EX-stage combinational ALU.
- Keeps the existing 4-bit exe_command encoding and {N,Z,C,V} status.
- Adds correct C/V for all add/subtract forms, a registered output with valid/ready flow control, and an iterative shift-add multiplier (MUL, MLA).
- Sits between the ID/EX register and the EX/MEM register; stalls upstream via in_ready while a multiply is running.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 49 ++++
 rtl/alu_mc.sv | 104 ++++++++++
 tb/tb_alu_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, status bit indices and FSM states for alu_mc
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU datapath producing result and {N,Z,C,V}
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   cmd,
  input  logic [W-1:0] val1,
  input  logic [W-1:0] val2,
  input  logic         carry,
  output logic [W-1:0] res,
  output logic [3:0]   st
);

  logic [W-1:0] b_eff;
  logic         cin;
  logic         arith;
  logic [W:0]   sum;

  // Subtracts run through the same adder as val1 + ~val2 + cin, so C is the ARM no-borrow flag
  always_comb begin
    b_eff = val2;
    cin   = 1'b0;
    arith = 1'b0;
    res   = '0;
    st    = '0;
    case (cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = carry; end
      CMD_SUB: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_eff = ~val2; cin = carry; end
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = val1 & val2;
      CMD_ORR: res = val1 | val2;
      CMD_EOR: res = val1 ^ val2;
      default: res = '0;
    endcase
    sum = {1'b0, val1} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    if (arith) begin
      res      = sum[W-1:0];
      st[ST_C] = sum[W];
      st[ST_V] = (val1[W-1] == b_eff[W-1]) && (sum[W-1] != val1[W-1]);
    end
    st[ST_N] = res[W-1];
    st[ST_Z] = (res == '0);
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked EX-stage ALU with registered output and iterative multiplier
module alu_mc
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   exe_command,
  input  logic [W-1:0] val1,
  input  logic [W-1:0] val2,
  input  logic [W-1:0] val3,
  input  logic         carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   status
);

  state_t           state, state_next;
  logic [W-1:0]     mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, is_mul, mul_done;
  logic [3:0]       comb_cmd;
  logic [W-1:0]     comb_v2, comb_res;
  logic [3:0]       comb_st;

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (exe_command == CMD_MUL) || (exe_command == CMD_MLA);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == MUL_RUN) && (cnt == CNT_W'(W-1));

  // During a multiply the datapath acts as MOV of the next accumulator to derive N/Z
  assign comb_cmd = (state == MUL_RUN) ? CMD_MOV : exe_command;
  assign comb_v2  = (state == MUL_RUN) ? acc_next : val2;

  alu_comb #(.W(W)) u_comb (
    .cmd   (comb_cmd),
    .val1  (val1),
    .val2  (comb_v2),
    .carry (carry),
    .res   (comb_res),
    .st    (comb_st)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: enter MUL_RUN on a multiply accept, leave after the W-th iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul) state_next = MUL_RUN;
      MUL_RUN: if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier registers and the output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
    end else if (state == MUL_RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_done) begin
        result    <= acc_next;
        status    <= comb_st;
        out_valid <= 1'b1;
        cnt       <= '0;
      end
    end else if (accept) begin
      if (is_mul) begin
        mcand     <= val1;
        mplier    <= val2;
        acc       <= (exe_command == CMD_MLA) ? val3 : '0;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        result    <= comb_res;
        status    <= comb_st;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized and directed self-checking bench for alu_mc
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, carry, out_valid, out_ready;
  logic [3:0]  exe_command, status;
  logic [31:0] val1, val2, val3, result;

  logic        in_valid8, in_ready8, out_valid8;
  logic [3:0]  status8;
  logic [7:0]  a8, b8, result8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exe_command(exe_command), .val1(val1), .val2(val2), .val3(val3),
    .carry(carry), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status)
  );

  alu_mc #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .exe_command(4'b1010), .val1(a8), .val2(b8), .val3(8'h00),
    .carry(1'b0), .out_valid(out_valid8), .out_ready(1'b1),
    .result(result8), .status(status8)
  );

  // Reference: {N,Z,C,V,result} from the arithmetic definition of each opcode
  function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic cy);
    logic [31:0] r;
    logic        cf, vf;
    longint      sa, sb, full;
    longint      ua, ub, ucy, bor;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ucy = cy ? 64'sd1 : 64'sd0;
    bor = cy ? 64'sd0 : 64'sd1;
    cf = 1'b0; vf = 1'b0; full = 0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b0010: begin r = a + b;       cf = (ua + ub) > 64'sd4294967295;       full = sa + sb; end
      4'b0011: begin r = a + b + {31'b0, cy}; cf = (ua + ub + ucy) > 64'sd4294967295; full = sa + sb + ucy; end
      4'b0100: begin r = a - b;       cf = ua >= ub;                           full = sa - sb; end
      4'b0101: begin r = a - b - {31'b0, ~cy}; cf = ua >= ub + bor;            full = sa - sb - bor; end
      4'b1010: r = a * b;
      4'b1011: r = a * b + c;
      default: r = 32'b0;
    endcase
    if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101})
      vf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    return {r[31], (r == 32'b0), cf, vf, r};
  endfunction

  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic cy);
    int n;
    @(negedge clk);
    exe_command = cmd; val1 = a; val2 = b; val3 = c; carry = cy; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns edges elapsed and whether in_ready stayed low meanwhile
  task automatic wait_out(output int edges, output logic rdy_low);
    edges = 0; rdy_low = 1'b1;
    while (!out_valid && edges < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; edges++;
    end
    tests++;
    if (!out_valid) begin fails++; $display("FAIL wait_out_timeout: out_valid=0 required 1"); end
  endtask

  task automatic check_op(input string name, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic cy);
    logic [35:0] exp;
    int          e;
    logic        rl;
    exp = model(cmd, a, b, c, cy);
    send(cmd, a, b, c, cy);
    if (cmd == 4'b1010 || cmd == 4'b1011) wait_out(e, rl);
    tests++;
    if ({status, result} !== exp || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: got st=%b res=%h v=%b required st=%b res=%h", name, status, result,
               out_valid, exp[35:32], exp[31:0]);
    end
  endtask

  task automatic test_reset;
    int e;
    rst_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
    exe_command = 4'b0; val1 = 0; val2 = 0; val3 = 0; carry = 0; a8 = 0; b8 = 0;
    #12;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'b0 || status !== 4'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: v=%b res=%h st=%b rdy=%b required 0", out_valid, result, status, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    check_op("pre_reset_add", 4'b0010, 32'd1, 32'd1, 32'd0, 1'b0);
    send(4'b1010, 32'd3, 32'd5, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'b0 || status !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid_mul: v=%b res=%h st=%b required 0", out_valid, result, status);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
    e = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) e++; end
    tests++;
    if (e != 0) begin fails++; $display("FAIL reset_stale_output: %0d valid cycles required 0", e); end
  endtask

  task automatic test_add_sub;
    out_ready = 1'b1;
    check_op("add_carry", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    tests++;
    if (result !== 32'h0 || status !== 4'b0110) begin
      fails++; $display("FAIL add_carry_const: got %h/%b required 0/0110", result, status);
    end
    check_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0);
    tests++;
    if (result !== 32'h80000000 || status !== 4'b1001) begin
      fails++; $display("FAIL add_ovf_const: got %h/%b required 80000000/1001", result, status);
    end
    check_op("sub_eq", 4'b0100, 32'd5, 32'd5, 32'd0, 1'b0);
    tests++;
    if (result !== 32'h0 || status !== 4'b0110) begin
      fails++; $display("FAIL sub_eq_const: got %h/%b required 0/0110", result, status);
    end
    check_op("sub_borrow", 4'b0100, 32'd0, 32'd1, 32'd0, 1'b0);
    tests++;
    if (result !== 32'hFFFFFFFF || status !== 4'b1000) begin
      fails++; $display("FAIL sub_borrow_const: got %h/%b required ffffffff/1000", result, status);
    end
    check_op("sbc_c0", 4'b0101, 32'd5, 32'd2, 32'd0, 1'b0);
    tests++;
    if (result !== 32'd2 || status !== 4'b0010) begin
      fails++; $display("FAIL sbc_c0_const: got %h/%b required 2/0010", result, status);
    end
    check_op("adc_c1", 4'b0011, 32'h80000000, 32'h80000000, 32'd0, 1'b1);
  endtask

  task automatic test_multiply;
    int   e;
    logic rl;
    out_ready = 1'b1;
    send(4'b1010, 32'h0000FFFF, 32'h00010001, 32'd0, 1'b0);
    wait_out(e, rl);
    tests++;
    if (e != 32 || !rl || result !== 32'hFFFFFFFF || status !== 4'b1000) begin
      fails++;
      $display("FAIL mul_latency: edges=%0d rdy_low=%b res=%h st=%b required 32/1/ffffffff/1000", e, rl, result, status);
    end
    check_op("mla", 4'b1011, 32'd7, 32'd6, 32'd100, 1'b0);
    tests++;
    if (result !== 32'd142) begin fails++; $display("FAIL mla_const: got %0d required 142", result); end
    @(negedge clk); a8 = 8'd16; b8 = 8'd16; in_valid8 = 1'b1;
    @(posedge clk); #1; in_valid8 = 1'b0;
    e = 0;
    while (!out_valid8 && e < 100) begin @(posedge clk); #1; e++; end
    tests++;
    if (e != 8 || result8 !== 8'h00 || status8 !== 4'b0100) begin
      fails++; $display("FAIL mul_w8: edges=%0d res=%h st=%b required 8/00/0100", e, result8, status8);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    out_ready = 1'b0;
    check_op("orr", 4'b0111, 32'hF0, 32'h0F, 32'd0, 1'b0);
    @(negedge clk);
    exe_command = 4'b0001; val2 = 32'h55; in_valid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'hFF) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL backpressure_hold: %0d bad cycles required 0", bad); end
    @(negedge clk); out_ready = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL backpressure_release: rdy=%b required 1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 32'h55) begin
      fails++; $display("FAIL backpressure_same_edge: v=%b res=%h required 1/55", out_valid, result);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL out_clear: v=%b required 0", out_valid); end
  endtask

  task automatic test_undefined;
    out_ready = 1'b1;
    check_op("undef_f", 4'b1111, 32'h1234, 32'h5678, 32'd0, 1'b1);
    tests++;
    if (result !== 32'h0 || status !== 4'b0100) begin
      fails++; $display("FAIL undef_const: got %h/%b required 0/0100", result, status);
    end
    check_op("undef_0", 4'b0000, 32'hFFFF, 32'hFFFF, 32'd0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    int          bad;
    out_ready = 1'b1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v = $urandom; exe_command = 4'b0001; val2 = v; in_valid = 1'b1;
      if (!in_ready) bad++;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== v) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL back_to_back: %0d bubbles/errors required 0", bad); end
  endtask

  task automatic test_random;
    logic [3:0] ops [11];
    ops = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1011};
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFFFFFF};
      check_op("random", ops[$urandom_range(0, 10)], a, b, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_multiply;
    test_backpressure;
    test_undefined;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
